// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO read-side streamer.
//  WIDTH_DEF / CNT_W_DEF : default data width and delivered-beat counter width
//  occ_t                 : skid-buffer occupancy (0..2 words)
//  data_t                : data word at the default width
package fifo_stream_pkg;

  localparam int WIDTH_DEF = 1024;
  localparam int CNT_W_DEF = 16;

  typedef logic [1:0]           occ_t;
  typedef logic [WIDTH_DEF-1:0] data_t;

  localparam occ_t OCC_MAX = 2'd2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer (slot0/slot1) presenting slot0 as a valid/ready stream.
//  clk, reset  : clock, asynchronous active-high reset
//  push        : store push_data this cycle
//  push_data   : word to store
//  pop         : sink consumed the word in slot0 this cycle
//  flush       : drop all buffered words (occupancy -> 0)
//  valid       : slot0 holds a word
//  data        : slot0 contents (registered)
//  occ         : number of buffered words
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output occ_t             occ
);

  logic [WIDTH-1:0] slot0_q;
  logic [WIDTH-1:0] slot1_q;
  occ_t             occ_q;
  occ_t             occ_next;
  logic             pop_eff;
  logic             land_slot0;

  assign pop_eff = pop & (occ_q != 2'd0);

  // A new word goes straight to the head when the head is free or is being
  // consumed with nothing behind it; otherwise it queues in slot1.
  assign land_slot0 = (occ_q == 2'd0) | ((occ_q == 2'd1) & pop_eff);

  always_comb begin
    occ_next = occ_q;
    if (flush) begin
      occ_next = '0;
    end else begin
      occ_next = occ_q + occ_t'(push) - occ_t'(pop_eff);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (!flush) begin
      if (push && land_slot0) begin
        slot0_q <= push_data;
      end else if (pop_eff && (occ_q == OCC_MAX)) begin
        slot0_q <= slot1_q;
      end
      if (push && !land_slot0) begin
        slot1_q <= push_data;
      end
    end
  end

  assign valid = (occ_q != 2'd0);
  assign data  = slot0_q;
  assign occ   = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && !pop_eff && (occ_q == OCC_MAX)));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side drain stage for a synchronous FIFO. Issues FIFO reads whenever the
// skid buffer can absorb the word (which returns one clock after the read),
// and re-presents the words as a valid/ready stream at up to one beat per
// clock. Counts delivered beats.
//  clk, reset    : clock, asynchronous active-high reset
//  i_enable      : allow new FIFO reads
//  i_flush       : drop buffered and landing words
//  i_fifo_empty  : FIFO empty flag
//  o_fifo_rden   : FIFO read enable
//  i_fifo_data   : FIFO read data, valid one clock after an accepted read
//  o_valid       : stream valid
//  i_ready       : stream sink ready
//  o_data        : stream data
//  o_beat_cnt    : delivered beats (o_valid & i_ready), wraps
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_flush,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rden,
  input  logic [WIDTH-1:0] i_fifo_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_beat_cnt
);

  // Free room once this cycle's pop and any word already in flight are
  // accounted for; negative only if the buffer were over-committed.
  function automatic logic signed [2:0] calc_space(input occ_t occ,
                                                    input logic inflight,
                                                    input logic pop);
    logic signed [2:0] s;
    s = 3'sd2 - $signed({1'b0, occ}) - $signed({2'b00, inflight})
        + $signed({2'b00, pop});
    return s;
  endfunction

  occ_t              occ;
  logic              inflight_p1;
  logic              pop;
  logic              rd_accept;
  logic              land;
  logic signed [2:0] space;

  assign pop   = o_valid & i_ready;
  assign space = calc_space(occ, inflight_p1, pop);

  // Gated by reset so the FIFO sees no read while the streamer is held.
  assign o_fifo_rden = ~reset & i_enable & ~i_fifo_empty & ~i_flush
                     & (space > 3'sd0);
  assign rd_accept   = o_fifo_rden & ~i_fifo_empty;

  // Stage 1: read data returns; a word landing during flush is dropped.
  assign land = inflight_p1 & ~i_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_p1 <= 1'b0;
    end else begin
      inflight_p1 <= rd_accept;
    end
  end

  stream_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (land),
    .push_data (i_fifo_data),
    .pop       (pop),
    .flush     (i_flush),
    .valid     (o_valid),
    .data      (o_data),
    .occ       (occ)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_beat_cnt <= '0;
    end else if (pop) begin
      o_beat_cnt <= o_beat_cnt + CNT_W'(1);
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, occ} + {2'b00, inflight_p1}) <= 3'd2);

endmodule
